// File: rtl/dct_chen_pkg.sv
// Shared constants, types and helper functions for the 8-point Chen DCT engine.
// Cosine constants are derived from a Q24 table so any FRAC up to 23 rounds correctly.
package dct_chen_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CONST_W_DEF = 18;
    localparam int FRAC_DEF    = 8;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;
    typedef sample_t vec_t [8];

    // round(0.5*cos(k*pi/16) * 2^frac), wrapped into a signed const_w-bit value
    function automatic longint cos_const(input int k, input int frac, input int const_w);
        longint q24;
        longint v;
        longint span;
        case (k)
            1:       q24 = 64'sd8227423;
            2:       q24 = 64'sd7750063;
            3:       q24 = 64'sd6974873;
            4:       q24 = 64'sd5931642;
            5:       q24 = 64'sd4660461;
            6:       q24 = 64'sd3210181;
            7:       q24 = 64'sd1636536;
            default: q24 = 64'sd8388608;
        endcase
        v    = (q24 + (64'sd1 <<< (23 - frac))) >>> (24 - frac);
        span = 64'sd1 <<< const_w;
        v    = v & (span - 64'sd1);
        if (v >= (span >>> 1)) begin
            v = v - span;
        end
        return v;
    endfunction

    function automatic longint sat(input longint v, input int data_w);
        longint hi;
        longint lo;
        longint r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/dct8_chen_ts_if.sv
// Vector stream interface of the DCT engine: one 8-sample vector in, one coefficient vector out.
interface dct8_chen_ts_if
    import dct_chen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                     valid_in;
    logic signed [DATA_W-1:0] x [8];
    logic                     valid_out;
    logic signed [DATA_W-1:0] y [8];

    modport master (output valid_in, x, input valid_out, y);
    modport slave  (input valid_in, x, output valid_out, y);
endinterface

// File: rtl/dct8_chen_odd.sv
// Odd half of the Chen butterfly: registered 4x4 constant multiply-accumulate b -> p1,p3,p5,p7.
module dct8_chen_odd
    import dct_chen_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CONST_W = CONST_W_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int P_W     = DATA_W + CONST_W + 4
) (
    input  logic                   clk,
    input  logic signed [DATA_W:0] b     [4],
    output logic signed [P_W-1:0]  p_odd [4]
);

    localparam logic signed [P_W-1:0] C1 = P_W'(cos_const(1, FRAC, CONST_W));
    localparam logic signed [P_W-1:0] C3 = P_W'(cos_const(3, FRAC, CONST_W));
    localparam logic signed [P_W-1:0] C5 = P_W'(cos_const(5, FRAC, CONST_W));
    localparam logic signed [P_W-1:0] C7 = P_W'(cos_const(7, FRAC, CONST_W));

    logic signed [P_W-1:0] bx     [4];
    logic signed [P_W-1:0] p_next [4];

    // Operands are widened to the full accumulator width so no partial sum can wrap
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bx[i] = P_W'(b[i]);
        end
        p_next[0] = C1 * bx[0] + C3 * bx[1] + C5 * bx[2] + C7 * bx[3];
        p_next[1] = C3 * bx[0] - C7 * bx[1] - C1 * bx[2] - C5 * bx[3];
        p_next[2] = C5 * bx[0] - C1 * bx[1] + C7 * bx[2] + C3 * bx[3];
        p_next[3] = C7 * bx[0] - C5 * bx[1] + C3 * bx[2] - C1 * bx[3];
    end

    always_ff @(posedge clk) begin
        p_odd <= p_next;
    end

endmodule

// File: rtl/dct8_chen_ts.sv
// 3-stage pipelined 8-point DCT-II (Chen factorisation): butterfly, constant products, round+saturate.
// Only the valid pipe and y are reset; the datapath loads unconditionally every cycle.
module dct8_chen_ts
    import dct_chen_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CONST_W = CONST_W_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input logic           clk,
    input logic           rst,
    dct8_chen_ts_if.slave bus
);

    localparam int A_W = DATA_W + 1;
    localparam int P_W = DATA_W + CONST_W + 4;

    localparam logic signed [P_W-1:0] C2   = P_W'(cos_const(2, FRAC, CONST_W));
    localparam logic signed [P_W-1:0] C4   = P_W'(cos_const(4, FRAC, CONST_W));
    localparam logic signed [P_W-1:0] C6   = P_W'(cos_const(6, FRAC, CONST_W));
    localparam logic signed [P_W-1:0] HALF = P_W'(64'sd1 <<< (FRAC - 1));

    logic signed [A_W-1:0]    a      [4];
    logic signed [A_W-1:0]    b      [4];
    logic signed [P_W-1:0]    e0, e1, d0, d1;
    logic signed [P_W-1:0]    p_even_next [4];
    logic signed [P_W-1:0]    p_even [4];
    logic signed [P_W-1:0]    p_odd  [4];
    logic signed [P_W-1:0]    p_all  [8];
    logic signed [P_W-1:0]    rounded;
    logic signed [DATA_W-1:0] y_next [8];
    logic [2:0]               valid_pipe;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            a[i] <= A_W'(bus.x[i]) + A_W'(bus.x[7-i]);
            b[i] <= A_W'(bus.x[i]) - A_W'(bus.x[7-i]);
        end
    end

    always_comb begin
        e0 = P_W'(a[0]) + P_W'(a[3]);
        e1 = P_W'(a[1]) + P_W'(a[2]);
        d0 = P_W'(a[0]) - P_W'(a[3]);
        d1 = P_W'(a[1]) - P_W'(a[2]);
        p_even_next[0] = C4 * (e0 + e1);
        p_even_next[1] = C2 * d0 + C6 * d1;
        p_even_next[2] = C4 * (e0 - e1);
        p_even_next[3] = C6 * d0 - C2 * d1;
    end

    always_ff @(posedge clk) begin
        p_even <= p_even_next;
    end

    dct8_chen_odd #(
        .DATA_W (DATA_W),
        .CONST_W(CONST_W),
        .FRAC   (FRAC),
        .P_W    (P_W)
    ) u_odd (
        .clk  (clk),
        .b    (b),
        .p_odd(p_odd)
    );

    // Even indices come from the even half, odd indices from the odd half
    always_comb begin
        rounded = '0;
        for (int k = 0; k < 4; k++) begin
            p_all[2*k]   = p_even[k];
            p_all[2*k+1] = p_odd[k];
        end
        for (int k = 0; k < 8; k++) begin
            rounded   = (p_all[k] + HALF) >>> FRAC;
            y_next[k] = DATA_W'(sat(longint'(rounded), DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
            for (int k = 0; k < 8; k++) begin
                bus.y[k] <= '0;
            end
        end else begin
            valid_pipe <= {valid_pipe[1:0], bus.valid_in};
            bus.y      <= y_next;
        end
    end

    assign bus.valid_out = valid_pipe[2];

endmodule

// File: tb/tb_dct8_chen_ts.sv
// Directed self-checking bench for dct8_chen_ts: reset, DC, impulse, saturation, streaming, bubbles, mid-flight reset.
module tb_dct8_chen_ts;
    import dct_chen_pkg::*;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dct8_chen_ts_if #(.DATA_W(DATA_W_DEF)) bus ();

    dct8_chen_ts #(
        .DATA_W (DATA_W_DEF),
        .CONST_W(CONST_W_DEF),
        .FRAC   (FRAC_DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic vec_t fill(input int val);
        vec_t v;
        for (int i = 0; i < 8; i++) begin
            v[i] = sample_t'(val);
        end
        return v;
    endfunction

    task automatic drive(input logic v, input vec_t xv);
        bus.valid_in = v;
        bus.x        = xv;
    endtask

    // One vector followed by idle cycles; returns valid_out seen after edges 1..3 and the final y
    task automatic run_single(input vec_t xv, output logic [2:0] vseen, output vec_t yout);
        @(negedge clk);
        drive(1'b1, xv);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b0, fill(0));
            vseen[c] = bus.valid_out;
        end
        yout = bus.y;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, fill(0));
        repeat (3) @(negedge clk);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid got=%b exp=0", bus.valid_out);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (int'(bus.y[k]) !== 0) begin
                failures++;
                $display("[TB] FAIL reset_y%0d got=%0d exp=0", k, bus.y[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_dc;
        logic [2:0] vs;
        vec_t       yo;
        int         exp_y [8] = '{284, 0, 0, 0, 0, 0, 0, 0};
        run_single(fill(100), vs, yo);
        checks++;
        if (vs !== 3'b100) begin
            failures++;
            $display("[TB] FAIL dc_latency got=%b exp=100", vs);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (int'(yo[k]) !== exp_y[k]) begin
                failures++;
                $display("[TB] FAIL dc_y%0d got=%0d exp=%0d", k, yo[k], exp_y[k]);
            end
        end
    endtask

    task automatic test_impulse;
        logic [2:0] vs;
        vec_t       xv;
        vec_t       yo;
        int         exp_y [8] = '{91, 126, 118, 106, 91, 71, 49, 25};
        xv    = fill(0);
        xv[0] = sample_t'(256);
        run_single(xv, vs, yo);
        checks++;
        if (vs !== 3'b100) begin
            failures++;
            $display("[TB] FAIL impulse_latency got=%b exp=100", vs);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (int'(yo[k]) !== exp_y[k]) begin
                failures++;
                $display("[TB] FAIL impulse_y%0d got=%0d exp=%0d", k, yo[k], exp_y[k]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [2:0] vs;
        vec_t       yo;
        int         in_val [2] = '{32767, -32768};
        int         exp_dc [2] = '{32767, -32768};
        for (int t = 0; t < 2; t++) begin
            run_single(fill(in_val[t]), vs, yo);
            checks++;
            if (vs !== 3'b100) begin
                failures++;
                $display("[TB] FAIL sat%0d_latency got=%b exp=100", t, vs);
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (int'(yo[k]) !== ((k == 0) ? exp_dc[t] : 0)) begin
                    failures++;
                    $display("[TB] FAIL sat%0d_y%0d got=%0d exp=%0d", t, k, yo[k],
                             (k == 0) ? exp_dc[t] : 0);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        vec_t vecs [16];
        real  model;
        real  diff;
        int   run_len = 0;
        int   idx;
        logic exp_valid;
        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < 8; i++) begin
                vecs[v][i] = sample_t'(int'($urandom_range(128)) - 64);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                idx       = c - 3;
                exp_valid = (idx < 16);
                checks++;
                if (bus.valid_out !== exp_valid) begin
                    failures++;
                    $display("[TB] FAIL stream_valid_c%0d got=%b exp=%b", c, bus.valid_out, exp_valid);
                end
                if (bus.valid_out === 1'b1) run_len++;
                if (exp_valid) begin
                    for (int k = 0; k < 8; k++) begin
                        model = 0.0;
                        for (int n = 0; n < 8; n++) begin
                            model += real'(int'(vecs[idx][n])) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
                        end
                        model = model * ((k == 0) ? (1.0 / (2.0 * $sqrt(2.0))) : 0.5);
                        diff  = real'(int'(bus.y[k])) - model;
                        checks++;
                        if (diff > 2.0 || diff < -2.0) begin
                            failures++;
                            $display("[TB] FAIL stream_v%0d_y%0d got=%0d exp=%f", idx, k, bus.y[k], model);
                        end
                    end
                end
            end
            if (c < 16) drive(1'b1, vecs[c]);
            else        drive(1'b0, fill(0));
        end
        checks++;
        if (run_len !== 16) begin
            failures++;
            $display("[TB] FAIL stream_run_len got=%0d exp=16", run_len);
        end
    endtask

    task automatic test_bubbles;
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (bus.valid_out !== ((c - 3 < 5) ? pat[c-3] : 1'b0)) begin
                    failures++;
                    $display("[TB] FAIL bubble_c%0d got=%b exp=%b", c, bus.valid_out,
                             (c - 3 < 5) ? pat[c-3] : 1'b0);
                end
            end
            if (c < 5) drive(pat[c], fill(c * 10 + 1));
            else       drive(1'b0, fill(0));
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        drive(1'b1, fill(50));
        @(negedge clk);
        drive(1'b1, fill(60));
        @(negedge clk);
        drive(1'b0, fill(0));
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_valid got=%b exp=0", bus.valid_out);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (int'(bus.y[k]) !== 0) begin
                failures++;
                $display("[TB] FAIL midrst_y%0d got=%0d exp=0", k, bus.y[k]);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.valid_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midrst_after_c%0d got=%b exp=0", c, bus.valid_out);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, fill(0));
        test_reset();
        test_dc();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_bubbles();
        test_reset_midflight();
        test_impulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
